bcd_stopwatch: RTL and testbench

Stopwatch core that feeds the multiplexed seven-segment display driver. It debounces the push-buttons, generates the counting tick and keeps an MM:SS time value as four packed BCD digits. The display driver consumes the `digits` bus one nibble per display position.

---
 rtl/bcd_stopwatch_pkg.sv | 40 ++++
 rtl/bcd_stopwatch_key_debounce.sv | 50 +++++
 rtl/bcd_stopwatch.sv | 158 +++++++++++++++
 tb/tb_bcd_stopwatch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM states, digit limits
// and the MM:SS ripple-increment helper.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} sw_state_e;

  // Returns {rollover, next_value}; rollover is set when 59:59 goes to 00:00.
  function automatic logic [4*DIGIT_W:0] bcd_inc(input logic [4*DIGIT_W-1:0] v);
    logic [DIGIT_W-1:0] d0, d1, d2, d3;
    logic               c;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    d3 = v[15:12];
    c  = 1'b1;
    if (d0 == SEC_ONES_MAX) d0 = '0;
    else begin d0 = d0 + 4'd1; c = 1'b0; end
    if (c) begin
      if (d1 == SEC_TENS_MAX) d1 = '0;
      else begin d1 = d1 + 4'd1; c = 1'b0; end
    end
    if (c) begin
      if (d2 == MIN_ONES_MAX) d2 = '0;
      else begin d2 = d2 + 4'd1; c = 1'b0; end
    end
    if (c) begin
      if (d3 == MIN_TENS_MAX) d3 = '0;
      else begin d3 = d3 + 4'd1; c = 1'b0; end
    end
    return {c, d3, d2, d1, d0};
  endfunction

endpackage

// File: rtl/bcd_stopwatch_key_debounce.sv
// One push-button path: 2-FF synchronizer, stability counter, debounced level
// and a single-cycle press pulse on the debounced high-to-low transition.
module key_debounce #(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DB_CYC - 1)) begin
      cnt_d   = '0;
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS BCD stopwatch core for the seven-segment driver. Optional lap hold is
// enabled by defining STOPWATCH_LAP_EN.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 1,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [1:0]  KEY,
`ifdef STOPWATCH_LAP_EN
  input  logic        KEY_LAP,
`endif
  output logic [15:0] digits,
  output logic        running,
  output logic        update,
  output logic        wrap
);
  localparam int TPC    = CLK_HZ / TICK_HZ;
  localparam int PW     = (TPC > 1) ? $clog2(TPC) : 1;
  localparam int DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
`ifdef STOPWATCH_LAP_EN
  localparam int NK = 3;
`else
  localparam int NK = 2;
`endif

  logic [NK-1:0] key_raw, key_press;

`ifdef STOPWATCH_LAP_EN
  assign key_raw = {KEY_LAP, KEY};
`else
  assign key_raw = KEY;
`endif

  for (genvar k = 0; k < NK; k++) begin : g_key
    key_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk  (CLOCK_50),
      .rst_n(RESET_N),
      .key_n(key_raw[k]),
      .press(key_press[k])
    );
  end

  logic sp, clr;
  assign sp  = key_press[1];
  assign clr = key_press[0];

  sw_state_e   state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0] cnt_q, cnt_d, disp_q, disp_d;
  logic        running_q, running_d, update_q, update_d, wrap_q, wrap_d;
  logic        tick, roll;
  logic [16:0] inc;
`ifdef STOPWATCH_LAP_EN
  logic        hold_q, hold_d, rel;
  logic [15:0] hold_val_q, hold_val_d;
`endif

  assign tick = (state_q == RUN) && (presc_q == PW'(TPC - 1));
  assign inc  = bcd_inc(cnt_q);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    roll    = 1'b0;
    case (state_q)
      IDLE: if (sp) state_d = RUN;
      RUN: begin
        // Clear overrides a coincident tick; start/pause still applies after it.
        if (clr) begin
          presc_d = '0;
          cnt_d   = '0;
        end else if (tick) begin
          presc_d = '0;
          cnt_d   = inc[15:0];
          roll    = inc[16];
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (sp) state_d = PAUSED;
      end
      PAUSED: begin
        if (clr) begin
          presc_d = '0;
          cnt_d   = '0;
          state_d = sp ? RUN : IDLE;
        end else if (sp) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);

`ifdef STOPWATCH_LAP_EN
    hold_d     = hold_q;
    hold_val_d = hold_val_q;
    rel        = 1'b0;
    if (clr && state_q != IDLE) begin
      hold_d = 1'b0;
      rel    = hold_q;
    end else if (key_press[2]) begin
      if (hold_q) begin
        hold_d = 1'b0;
        rel    = 1'b1;
      end else if (state_q == RUN) begin
        hold_d     = 1'b1;
        hold_val_d = cnt_q;
      end
    end
    disp_d   = hold_d ? hold_val_d : cnt_d;
    update_d = !hold_d && (rel || disp_d != disp_q);
    wrap_d   = roll && !hold_d;
`else
    disp_d   = cnt_d;
    update_d = (disp_d != disp_q);
    wrap_d   = roll;
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      running_q  <= 1'b0;
      update_q   <= 1'b0;
      wrap_q     <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      hold_q     <= 1'b0;
      hold_val_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      running_q  <= running_d;
      update_q   <= update_d;
      wrap_q     <= wrap_d;
`ifdef STOPWATCH_LAP_EN
      hold_q     <= hold_d;
      hold_val_q <= hold_val_d;
`endif
    end
  end

  assign digits  = disp_q;
  assign running = running_q;
  assign update  = update_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch at TPC=10, DB_CYC=4: directed key sequences feed an
// expected-update queue that a negedge monitor drains on every update pulse.
module tb_bcd_stopwatch;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  key   = 2'b11;
`ifdef STOPWATCH_LAP_EN
  logic        key_lap = 1'b1;
`endif
  logic [15:0] digits;
  logic        running, update, wrap;

  always #5 clk = ~clk;

  bcd_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_MS(4)) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .KEY     (key),
`ifdef STOPWATCH_LAP_EN
    .KEY_LAP (key_lap),
`endif
    .digits  (digits),
    .running (running),
    .update  (update),
    .wrap    (wrap)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        w;
  } exp_t;

  exp_t q[$];
  int   nvec = 0, nerr = 0, upd_cnt = 0, wrap_cnt = 0;

  function automatic logic [15:0] to_bcd(input int s);
    int m, sec;
    m   = (s / 60) % 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  task automatic push_exp(input int s);
    exp_t e;
    e.d = to_bcd(s % 3600);
    e.w = (s > 0) && (s % 3600 == 0);
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits for an update pulse (n>0: the n-th one overall), sampled 1ns after posedge.
  task automatic wait_upd(input int n, input int limit, input string name);
    int  i;
    bit  hit;
    i = 0;
    do begin
      @(posedge clk); #1;
      i++;
      hit = update && (n <= 0 || upd_cnt == n - 1);
    end while (!hit && i < limit);
    if (!hit) begin
      nvec++;
      nerr++;
      $display("FAIL %s: timeout after %0d cycles, updates seen %0d", name, i, upd_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wrap && !update) begin
        nvec++;
        nerr++;
        $display("FAIL wrap_without_update: digits=%h", digits);
      end
      if (update) begin
        upd_cnt++;
        if (wrap) wrap_cnt++;
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_update: digits=%h wrap=%b, none expected", digits, wrap);
        end else begin
          exp_t e;
          e = q.pop_front();
          nvec++;
          if (digits !== e.d || wrap !== e.w) begin
            nerr++;
            $display("FAIL update_%0d: digits=%h wrap=%b, expected digits=%h wrap=%b",
                     upd_cnt, digits, wrap, e.d, e.w);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    check("reset_digits", digits, 0);
    check("reset_running", running, 0);
    check("reset_update", update, 0);
    check("reset_wrap", wrap, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Bounce: 2-cycle toggles never satisfy the 4-cycle stability window.
    for (int i = 0; i < 10; i++) begin
      key[1] = ~key[1];
      repeat (2) @(negedge clk);
    end
    for (int s = 1; s <= 600; s++) push_exp(s);
    key[1] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 6) check("bounce_before_latency", running, 0);
      if (i == 7) check("bounce_start_at_7", running, 1);
    end
    repeat (30) @(posedge clk); #1;
    check("hold_single_press", running, 1);
    @(negedge clk) key[1] = 1'b1;

    wait_upd(60, 800, "tick60");
    check("carry_01_00", digits, 16'h0100);
    wait_upd(600, 6000, "tick600");
    check("carry_10_00", digits, 16'h1000);
    @(negedge clk); #1;
    check("update_count_600", upd_cnt, 600);

    for (int s = 601; s <= 3600; s++) push_exp(s);
    wait_upd(3599, 31000, "tick3599");
    check("pre_wrap_59_59", digits, 16'h5959);
    wait_upd(3600, 20, "tick3600");
    check("wrap_digits", digits, 0);
    check("wrap_pulse", wrap, 1);

    // Pause lands 3 cycles after the next tick (prescaler holds 3).
    push_exp(1);
    repeat (6) @(posedge clk);
    @(negedge clk) key[1] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 7) check("pause_entered", running, 0);
    end
    @(negedge clk) key[1] = 1'b1;
    repeat (100) @(posedge clk); #1;
    check("pause_frozen_digits", digits, 16'h0001);
    check("pause_no_updates", upd_cnt, 3601);

    push_exp(2);
    @(negedge clk) key[1] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 7) check("resume_running", running, 1);
    end
    repeat (6) @(posedge clk); #1;
    check("resume_no_early_tick", update, 0);
    @(posedge clk); #1;
    check("resume_tick_at_7", update, 1);
    check("resume_digits", digits, 16'h0002);

    // Clear lands on the same edge as the next tick.
    repeat (3) @(posedge clk);
    @(negedge clk) begin key[0] = 1'b0; key[1] = 1'b1; end
    push_exp(0);
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 7) begin
        check("clear_tick_digits", digits, 0);
        check("clear_tick_running", running, 1);
        check("clear_tick_update", update, 1);
      end
    end
    push_exp(1);
    @(negedge clk) key[0] = 1'b1;
    wait_upd(0, 20, "tick_after_clear");
    check("tick_after_clear_digits", digits, 16'h0001);

    @(negedge clk) key[1] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 7) check("pause_before_clear", running, 0);
    end
    @(negedge clk) key[1] = 1'b1;
    repeat (12) @(posedge clk);
    push_exp(0);
    @(negedge clk) key[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 7) begin
        check("clear_paused_running", running, 0);
        check("clear_paused_digits", digits, 0);
        check("clear_paused_update", update, 1);
      end
    end
    @(negedge clk) key[0] = 1'b1;
    repeat (30) @(posedge clk); #1;
    check("idle_stays_stopped", running, 0);
    check("idle_digits", digits, 0);

    // Async reset in the middle of a prescaler period.
    push_exp(1);
    push_exp(2);
    @(negedge clk) key[1] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 7) check("restart_running", running, 1);
    end
    @(negedge clk) key[1] = 1'b1;
    wait_upd(0, 20, "pre_reset_tick1");
    wait_upd(0, 20, "pre_reset_tick2");
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_digits", digits, 0);
    check("async_rst_running", running, 0);
    check("async_rst_update", update, 0);
    check("async_rst_wrap", wrap, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    push_exp(1);
    key[1] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 6) check("post_rst_before_latency", running, 0);
      if (i == 7) check("post_rst_running", running, 1);
    end
    repeat (9) @(posedge clk); #1;
    check("post_rst_no_early_tick", update, 0);
    @(posedge clk); #1;
    check("post_rst_first_tick", update, 1);
    check("post_rst_digits", digits, 16'h0001);
    @(negedge clk) key[1] = 1'b1;
    repeat (5) @(posedge clk); #1;

    check("queue_drained", q.size(), 0);
    check("wrap_count", wrap_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
